// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying a payload, a valid bit and a sticky flag,
// with stall/flush handling and saturating perf counters for hold, bubble and flush events.
module pipe_stage_reg #(
    parameter int                   PAYLOAD_W  = 128,
    parameter int                   STALL_W    = 6,
    parameter int                   STAGE      = 2,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
    parameter int                   CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_flag,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_flag,
    output logic [CNT_W-1:0]     hold_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2 || PAYLOAD_W < 1 || CNT_W < 1) begin : g_bad_params
            $error("pipe_stage_reg: illegal STAGE/STALL_W/PAYLOAD_W/CNT_W combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_LOAD
    } action_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic    up;
    logic    dn;
    logic    stall_unused;
    action_e act;

    assign up           = stall[STAGE];
    assign dn           = stall[STAGE+1];
    assign stall_unused = ^stall;

    // Priority decode: the first matching condition wins; !up & dn falls through to load.
    always_comb begin
        // NOTE: default assignment first so no path leaves act unassigned (no latch).
        act = ACT_LOAD;
        if (rst)
            act = ACT_RESET;
        else if (flush)
            act = ACT_FLUSH;
        else if (up && !dn)
            act = ACT_BUBBLE;
        else if (up && dn)
            act = ACT_HOLD;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        case (act)
            ACT_RESET, ACT_FLUSH: begin
                out_valid   <= 1'b0;
                out_payload <= BUBBLE_VAL;
                out_flag    <= 1'b0;
            end
            ACT_BUBBLE: begin
                // out_flag is kept so a delay-slot marker survives an upstream stall.
                out_valid   <= 1'b0;
                out_payload <= BUBBLE_VAL;
            end
            ACT_HOLD: ;
            default: begin
                out_valid   <= in_valid;
                out_payload <= in_payload;
                out_flag    <= in_flag;
            end
        endcase
    end

    // Saturating counters; clear beats any same-cycle event, reset beats clear.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hold_cnt   <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_HOLD && hold_cnt != CNT_MAX)
                hold_cnt <= hold_cnt + 1'b1;
            if (act == ACT_BUBBLE && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (act == ACT_FLUSH && out_valid && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // A downstream stall without an upstream stall is a ctrl protocol error.
    a_stall_protocol: assert property (@(posedge clk) disable iff (rst) !(!up && dn))
        else $error("pipe_stage_reg: stall[%0d]=0 with stall[%0d]=1", STAGE, STAGE + 1);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a behavioural model.
module tb_pipe_stage_reg;

    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic          in_flag;
    logic          cnt_clr;

    logic          out_valid,   s_out_valid;
    logic [PW-1:0] out_payload, s_out_payload;
    logic          out_flag,    s_out_flag;
    logic [15:0]   hold_cnt, bubble_cnt, flush_cnt;
    logic [3:0]    s_hold_cnt, s_bubble_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PAYLOAD_W(PW), .STALL_W(6), .STAGE(2), .BUBBLE_VAL('0), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_flag(in_flag), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_payload(out_payload), .out_flag(out_flag),
        .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation checks.
    pipe_stage_reg #(
        .PAYLOAD_W(PW), .STALL_W(6), .STAGE(2), .BUBBLE_VAL('0), .CNT_W(4)
    ) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_flag(in_flag), .cnt_clr(cnt_clr),
        .out_valid(s_out_valid), .out_payload(s_out_payload), .out_flag(s_out_flag),
        .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic [5:0]    stall;
        logic          flush;
        logic          in_valid;
        logic [PW-1:0] in_payload;
        logic          in_flag;
        logic          cnt_clr;
        logic          e_valid;
        logic [PW-1:0] e_payload;
        logic          e_flag;
        int            e_hold;
        int            e_bub;
        int            e_fl;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic v,
                         input logic [PW-1:0] p, input logic fl, input logic c);
        stall      = s;
        flush      = f;
        in_valid   = v;
        in_payload = p;
        in_flag    = fl;
        cnt_clr    = c;
    endtask

    task automatic check_main(input string tag, input logic v, input logic [PW-1:0] p,
                              input logic fl, input int h, input int b, input int f);
        check({tag, ".valid"},  64'(out_valid),   64'(v));
        check({tag, ".payload"},64'(out_payload), 64'(p));
        check({tag, ".flag"},   64'(out_flag),    64'(fl));
        check({tag, ".hold"},   64'(hold_cnt),    64'(h));
        check({tag, ".bubble"}, 64'(bubble_cnt),  64'(b));
        check({tag, ".flushc"}, 64'(flush_cnt),   64'(f));
    endtask

    function automatic int sat(input int raw, input int max);
        return (raw > max) ? max : raw;
    endfunction

    // Behavioural model state: counters are raw event counts since last clear.
    logic          m_valid;
    logic [PW-1:0] m_payload;
    logic          m_flag;
    int            m_hold, m_bub, m_fl;

    initial begin
        // T1..T4 plus flush-on-empty, clear-vs-bubble and invalid-load boundaries.
        vecs[0]  = '{6'b000000, 0, 1, 32'hA5, 1, 0,  1, 32'hA5, 1, 0, 0, 0};
        vecs[1]  = '{6'b000100, 0, 1, 32'h11, 0, 0,  0, 32'h00, 1, 0, 1, 0};
        vecs[2]  = '{6'b000000, 0, 1, 32'h3C, 0, 0,  1, 32'h3C, 0, 0, 1, 0};
        vecs[3]  = '{6'b001100, 0, 1, 32'hFF, 1, 0,  1, 32'h3C, 0, 1, 1, 0};
        vecs[4]  = '{6'b001100, 0, 1, 32'hFF, 1, 0,  1, 32'h3C, 0, 2, 1, 0};
        vecs[5]  = '{6'b001100, 0, 1, 32'hFF, 1, 0,  1, 32'h3C, 0, 3, 1, 0};
        vecs[6]  = '{6'b000000, 0, 1, 32'hFF, 1, 0,  1, 32'hFF, 1, 3, 1, 0};
        vecs[7]  = '{6'b000000, 0, 1, 32'h3C, 1, 0,  1, 32'h3C, 1, 3, 1, 0};
        vecs[8]  = '{6'b001100, 1, 1, 32'hEE, 1, 0,  0, 32'h00, 0, 3, 1, 1};
        vecs[9]  = '{6'b000000, 1, 1, 32'h55, 1, 0,  0, 32'h00, 0, 3, 1, 1};
        vecs[10] = '{6'b000100, 0, 1, 32'h66, 1, 1,  0, 32'h00, 0, 0, 0, 0};
        vecs[11] = '{6'b000000, 0, 0, 32'h77, 1, 0,  0, 32'h77, 1, 0, 0, 0};

        rst = 1'b1;
        drive(6'b0, 0, 0, '0, 0, 0);
        step();
        step();
        rst = 1'b0;
        check_main("reset", 0, 32'h0, 0, 0, 0, 0);
        check("reset.sat_bubble", 64'(s_bubble_cnt), 64'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].in_valid,
                  vecs[i].in_payload, vecs[i].in_flag, vecs[i].cnt_clr);
            step();
            check_main($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_payload,
                       vecs[i].e_flag, vecs[i].e_hold, vecs[i].e_bub, vecs[i].e_fl);
        end

        // T5: 20 bubbles saturate the 4-bit counter at 15; the 16-bit one reaches 20.
        drive(6'b000100, 0, 1, 32'h1234, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("t5.sat_bubble",  64'(s_bubble_cnt), 64'd15);
        check("t5.main_bubble", 64'(bubble_cnt),   64'd20);
        check("t5.flag_kept",   64'(out_flag),     64'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("t5.sat_clr",  64'(s_bubble_cnt), 64'd0);
        check("t5.main_clr", 64'(bubble_cnt),   64'd0);

        // T6: reset in the middle of a hold.
        drive(6'b000000, 0, 1, 32'h99, 1, 0);
        step();
        drive(6'b001100, 0, 1, 32'hAB, 0, 0);
        for (int i = 0; i < 5; i++) step();
        check_main("t6.hold", 1, 32'h99, 1, 5, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_main("t6.rst", 0, 32'h0, 0, 0, 0, 0);
        drive(6'b000000, 0, 1, 32'h12, 0, 0);
        step();
        check_main("t6.load", 1, 32'h12, 0, 0, 0, 0);

        // Randomized traffic against the model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_valid = 0; m_payload = '0; m_flag = 0; m_hold = 0; m_bub = 0; m_fl = 0;
        for (int i = 0; i < 400; i++) begin
            int  mode;
            logic [5:0] s;
            mode = int'($urandom_range(0, 2));
            s    = 6'($urandom);
            s[2] = (mode != 0);
            s[3] = (mode == 2);
            drive(s, ($urandom_range(0, 9) == 0), 1'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 19) == 0));
            rst = ($urandom_range(0, 99) < 3);

            if (rst) begin
                m_valid = 0; m_payload = '0; m_flag = 0; m_hold = 0; m_bub = 0; m_fl = 0;
            end else begin
                int dh, db, df;
                dh = (!flush && mode == 2) ? 1 : 0;
                db = (!flush && mode == 1) ? 1 : 0;
                df = (flush && m_valid) ? 1 : 0;
                if (flush) begin
                    m_valid = 0; m_payload = '0; m_flag = 0;
                end else if (mode == 1) begin
                    m_valid = 0; m_payload = '0;
                end else if (mode == 0) begin
                    m_valid = in_valid; m_payload = in_payload; m_flag = in_flag;
                end
                if (cnt_clr) begin
                    m_hold = 0; m_bub = 0; m_fl = 0;
                end else begin
                    m_hold += dh; m_bub += db; m_fl += df;
                end
            end

            step();
            rst = 1'b0;
            check_main($sformatf("rnd%0d", i), m_valid, m_payload, m_flag,
                       sat(m_hold, 65535), sat(m_bub, 65535), sat(m_fl, 65535));
            check($sformatf("rnd%0d.sat_hold", i),   64'(s_hold_cnt),   64'(sat(m_hold, 15)));
            check($sformatf("rnd%0d.sat_bubble", i), 64'(s_bubble_cnt), 64'(sat(m_bub, 15)));
            check($sformatf("rnd%0d.sat_flush", i),  64'(s_flush_cnt),  64'(sat(m_fl, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
